// File: rtl/adc0808_conv_ctrl.sv
// Conversion sequencer for an ADC0808/0809-style converter: clock divider,
// request edge detect, address/ALE/START/EOC/OE handshake and an EOC watchdog.
module adc0808_conv_ctrl #(
  parameter int CLK_DIV     = 50,
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_signal,
  input  logic [2:0] address_in,
  input  logic       eoc_in,
  input  logic [7:0] adc_data_in,
  output logic       clk_adc,
  output logic [2:0] adc_addr,
  output logic       ale,
  output logic       start,
  output logic       oe,
  output logic [7:0] data_out,
  output logic       done_pulse,
  output logic       busy,
  output logic       timeout_err
);

  // state   | meaning
  // IDLE    | waiting for a rising edge on init_signal
  // SETUP   | channel address driven, settling before ALE
  // ALE     | address latch pulse
  // START   | start-of-conversion pulse
  // WAIT_LO | waiting for EOC to drop (conversion running)
  // WAIT_HI | waiting for EOC to return high (result ready)
  // READ    | OE asserted, byte latched on the last cycle
  // DONE    | one-cycle completion strobe
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ALE, S_START, S_WAIT_LO, S_WAIT_HI, S_READ, S_DONE
  } state_t;

  localparam int MAX_AB = (CLK_DIV > SETUP_CYC) ? CLK_DIV : SETUP_CYC;
  localparam int MAX_CD = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
  localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          clk_adc_q, clk_adc_d;
  logic          init_q, init_d;
  logic          eoc_s1_q, eoc_s1_d;
  logic          eoc_s2_q, eoc_s2_d;
  logic [2:0]    adc_addr_q, adc_addr_d;
  logic          ale_q, ale_d;
  logic          start_q, start_d;
  logic          oe_q, oe_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic          req;

  // Free-running divider, deliberately decoupled from the sequencer
  always_comb begin
    div_d     = div_q + DW'(1);
    clk_adc_d = clk_adc_q;
    if (div_q == DIV_LAST) begin
      div_d     = '0;
      clk_adc_d = ~clk_adc_q;
    end
  end

  always_comb begin
    init_d        = init_signal;
    eoc_s1_d      = eoc_in;
    eoc_s2_d      = eoc_s1_q;
    req           = init_signal & ~init_q;
    state_d       = state_q;
    adc_addr_d    = adc_addr_q;
    data_out_d    = data_out_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          adc_addr_d    = address_in;
          timeout_err_d = 1'b0;
          state_d       = S_SETUP;
        end
      end
      S_SETUP:   if (cnt_q == SETUP_LAST) state_d = S_ALE;
      S_ALE:     if (cnt_q == PULSE_LAST) state_d = S_START;
      S_START:   if (cnt_q == PULSE_LAST) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!eoc_s2_q) begin
          state_d = S_WAIT_HI;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_WAIT_HI: begin
        if (eoc_s2_q) begin
          state_d = S_READ;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_READ: begin
        if (cnt_q == PULSE_LAST) begin
          data_out_d = adc_data_in;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Phase counter restarts on every state entry and sticks at all-ones
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    ale_d   = (state_d == S_ALE);
    start_d = (state_d == S_START);
    oe_d    = (state_d == S_READ);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      clk_adc_q     <= 1'b0;
      init_q        <= 1'b0;
      eoc_s1_q      <= 1'b1;
      eoc_s2_q      <= 1'b1;
      adc_addr_q    <= 3'd0;
      ale_q         <= 1'b0;
      start_q       <= 1'b0;
      oe_q          <= 1'b0;
      data_out_q    <= 8'h00;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      clk_adc_q     <= clk_adc_d;
      init_q        <= init_d;
      eoc_s1_q      <= eoc_s1_d;
      eoc_s2_q      <= eoc_s2_d;
      adc_addr_q    <= adc_addr_d;
      ale_q         <= ale_d;
      start_q       <= start_d;
      oe_q          <= oe_d;
      data_out_q    <= data_out_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign clk_adc     = clk_adc_q;
  assign adc_addr    = adc_addr_q;
  assign ale         = ale_q;
  assign start       = start_q;
  assign oe          = oe_q;
  assign data_out    = data_out_q;
  assign done_pulse  = done_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc0808_conv_ctrl.sv
// Scoreboard bench for adc0808_conv_ctrl with a simple ADC0808 EOC model.
module tb_adc0808_conv_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_signal;
  logic [2:0] address_in;
  logic       eoc_in;
  logic [7:0] adc_data_in;
  logic       clk_adc;
  logic [2:0] adc_addr;
  logic       ale, start, oe;
  logic [7:0] data_out;
  logic       done_pulse, busy, timeout_err;

  adc0808_conv_ctrl #(
    .CLK_DIV(3), .SETUP_CYC(2), .PULSE_CYC(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset(reset), .init_signal(init_signal),
    .address_in(address_in), .eoc_in(eoc_in), .adc_data_in(adc_data_in),
    .clk_adc(clk_adc), .adc_addr(adc_addr), .ale(ale), .start(start),
    .oe(oe), .data_out(data_out), .done_pulse(done_pulse), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       to;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   done_count = 0;
  logic eoc_stuck = 1'b0;
  logic [7:0] last_data = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Converter model: EOC drops 3 cycles after START falls, returns 20 later
  initial begin
    eoc_in = 1'b1;
    forever begin
      @(negedge start);
      if (!eoc_stuck && reset) begin
        repeat (3) @(posedge clk);
        #1 eoc_in = 1'b0;
        repeat (20) @(posedge clk);
        #1 eoc_in = 1'b1;
      end
    end
  end

  // Output monitor, sampled on the falling edge
  int   cyc = 0;
  int   ale_w, start_w, oe_w, done_w;
  logic p_ale, p_start, p_oe, p_done, p_clk_adc;
  logic oe_seen;
  int   start_fall_cyc;
  int   overlap_cnt = 0;
  int   run_len, clk_runs = 0, clk_bad = 0;
  logic run_valid;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      ale_w = 0; start_w = 0; oe_w = 0; done_w = 0;
      p_ale = 0; p_start = 0; p_oe = 0; p_done = 0; p_clk_adc = 0;
      oe_seen = 0; run_valid = 0; run_len = 0;
    end else begin
      if (ale && start) overlap_cnt++;
      if (ale && !p_ale && sbq.size() > 0)
        check_eq("addr_before_ale", {29'd0, adc_addr}, {29'd0, sbq[0].addr});
      if (ale) ale_w++;
      else if (p_ale) begin check_eq("ale_width", ale_w, 4); ale_w = 0; end
      if (start) start_w++;
      else if (p_start) begin
        check_eq("start_width", start_w, 4);
        start_w = 0;
        start_fall_cyc = cyc;
      end
      if (oe) begin oe_w++; oe_seen = 1; end
      else if (p_oe) begin check_eq("oe_width", oe_w, 4); oe_w = 0; end

      if (done_pulse) done_w++;
      if (done_pulse && !p_done) begin
        check_eq("busy_during_done", {31'd0, busy}, 1);
        check_eq("sb_depth_at_done", {31'd0, sbq.size() > 0}, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check_eq("data_out", {24'd0, data_out}, {24'd0, e.data});
          check_eq("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
          check_eq("adc_addr_at_done", {29'd0, adc_addr}, {29'd0, e.addr});
          check_eq("oe_seen", {31'd0, oe_seen}, {31'd0, !e.to});
          if (e.to)
            check_eq("timeout_latency_ok",
                     {31'd0, (cyc - start_fall_cyc >= 100) && (cyc - start_fall_cyc <= 103)}, 1);
        end
        oe_seen = 0;
        done_count++;
      end
      if (!done_pulse && p_done) begin
        check_eq("done_width", done_w, 1);
        check_eq("busy_falls_with_done", {31'd0, busy}, 0);
        done_w = 0;
      end

      if (clk_adc != p_clk_adc) begin
        if (run_valid) begin
          clk_runs++;
          if (run_len != 3) clk_bad++;
        end
        run_valid = 1;
        run_len = 1;
      end else begin
        run_len++;
      end
      p_ale = ale; p_start = start; p_oe = oe; p_done = done_pulse; p_clk_adc = clk_adc;
    end
  end

  task automatic wait_done(input int budget);
    int base;
    bit got;
    base = done_count;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_count != base) begin got = 1; break; end
    end
    check_eq("wait_done_in_budget", {31'd0, got}, 1);
  endtask

  // Drop init for one cycle, then raise it with the given channel and data
  task automatic do_conv(input logic [2:0] ch, input logic [7:0] d, input logic stuck);
    exp_t x;
    init_signal = 1'b0;
    @(posedge clk); #1;
    address_in  = ch;
    adc_data_in = d;
    eoc_stuck   = stuck;
    init_signal = 1'b1;
    x.addr = ch;
    x.to   = stuck;
    x.data = stuck ? last_data : d;
    if (!stuck) last_data = d;
    sbq.push_back(x);
    repeat (2) @(posedge clk); #1;
    check_eq("busy_after_req", {31'd0, busy}, 1);
    check_eq("timeout_err_cleared", {31'd0, timeout_err}, 0);
    wait_done(400);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_clk_adc"}, {31'd0, clk_adc}, 0);
    check_eq({tag, "_adc_addr"}, {29'd0, adc_addr}, 0);
    check_eq({tag, "_ale"}, {31'd0, ale}, 0);
    check_eq({tag, "_start"}, {31'd0, start}, 0);
    check_eq({tag, "_oe"}, {31'd0, oe}, 0);
    check_eq({tag, "_data_out"}, {24'd0, data_out}, 0);
    check_eq({tag, "_done"}, {31'd0, done_pulse}, 0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 0);
    check_eq({tag, "_timeout_err"}, {31'd0, timeout_err}, 0);
  endtask

  initial begin
    int base;
    bit got;
    exp_t x;
    reset = 1'b0; init_signal = 1'b0; address_in = 3'd0; adc_data_in = 8'h00;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (5) @(posedge clk);

    do_conv(3'd5, 8'hA7, 1'b0);   // normal conversion
    do_conv(3'd2, 8'h3C, 1'b1);   // EOC stuck high
    do_conv(3'd0, 8'h11, 1'b0);   // back-to-back, clears timeout_err
    do_conv(3'd7, 8'hE4, 1'b0);

    // Level held high through more than two conversions' time
    base = done_count;
    repeat (150) @(posedge clk); #1;
    check_eq("level_no_retrigger", done_count - base, 0);

    // Re-edge while busy is dropped
    base = done_count;
    init_signal = 1'b0;
    @(posedge clk); #1;
    address_in = 3'd1; adc_data_in = 8'h5A; eoc_stuck = 1'b0; init_signal = 1'b1;
    x.addr = 3'd1; x.data = 8'h5A; x.to = 1'b0; last_data = 8'h5A;
    sbq.push_back(x);
    repeat (5) @(posedge clk); #1;
    init_signal = 1'b0;
    @(posedge clk); #1;
    init_signal = 1'b1;
    wait_done(400);
    repeat (100) @(posedge clk); #1;
    check_eq("busy_edge_single_done", done_count - base, 1);

    // Reset while OE is high
    init_signal = 1'b0;
    @(posedge clk); #1;
    address_in = 3'd6; adc_data_in = 8'h99; init_signal = 1'b1;
    x.addr = 3'd6; x.data = 8'h99; x.to = 1'b0;
    sbq.push_back(x);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (oe) begin got = 1; break; end
    end
    check_eq("oe_reached", {31'd0, got}, 1);
    base = done_count;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midread");
    sbq.delete();
    last_data = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check_eq("no_done_on_reset", done_count - base, 0);
    sbq.push_back(x);
    last_data = 8'h99;
    reset = 1'b1;
    wait_done(400);
    check_eq("restart_after_reset", done_count - base, 1);

    repeat (20) @(posedge clk); #1;
    check_eq("sb_empty_end", sbq.size(), 0);
    check_eq("ale_start_overlap", overlap_cnt, 0);
    check_eq("clk_adc_bad_runs", clk_bad, 0);
    check_eq("clk_adc_running", {31'd0, clk_runs > 100}, 1);
    check_eq("total_done", done_count, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
